full_adder: RTL and testbench
=============================

# full_adder

Single-bit (parameter-widenable) binary full adder: adds operands `a`, `b` and carry-in `cin`, and produces `sum` and carry-out `carry`. In the default configuration it is purely combinational, and the arithmetic leaf cell is used inside ripple adders and ALU datapaths. An optional output-register stage allows it to sit on a pipeline boundary. That stage uses the block's single clock and asynchronous active-low reset.

## Interface

Parameters:
- `WIDTH`, default 1 — operand width in bits; legal range 1..64.
- `OUT_REG`, default 0 — 0 makes the outputs combinational; 1 registers `sum`/`carry` on `clk`.

Ports:
- `clk`  input  1  — single clock; rising edge used only when `OUT_REG=1`.
- `rst_n`  input  1  — asynchronous, active-low reset; acts only when `OUT_REG=1`. May be left unconnected when `OUT_REG=0`.
- `a`  input  WIDTH  — operand A, unsigned.
- `b`  input  WIDTH  — operand B, unsigned.
- `cin`  input  1  — carry-in, weight 2^0.
- `sum`  output  WIDTH  — low WIDTH bits of `a + b + cin`.
- `carry`  output  1  — bit WIDTH of `a + b + cin` (carry-out).

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation

- Arithmetic: `{carry, sum} = a + b + cin`, computed at WIDTH+1 bits, unsigned; no overflow is lost.
- Per-bit cell, i = 0..WIDTH-1, with c0 = `cin`:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i))
- `carry` = c_WIDTH. Structure is a ripple chain of identical 1-bit cells; a carry-lookahead structure is permitted if the results are bit-identical.
- At WIDTH=1, the required truth table (a b cin -> sum carry):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- X/Z on any input may propagate to the outputs; no X-masking is required.
- `OUT_REG=0`:
  - `sum`/`carry` are continuous functions of the inputs; no state.
  - `clk` and `rst_n` are ignored.
- `OUT_REG=1`:
  - `sum`/`carry` are flops loaded with the combinational result on every rising `clk`; no enable.
  - `rst_n`=0 forces `sum`=0 and `carry`=0 immediately, independent of `clk`, and holds them while asserted.
  - The first load happens on the first rising `clk` after `rst_n` deasserts.

## Timing

- `OUT_REG=0`:
  - Latency is 0 cycles, purely combinational.
  - Outputs settle within the same timestep as an input change; no reset value applies.
  - A bench sampling 10 time units after driving inputs must see the final values.
- `OUT_REG=1`:
  - Latency is 1 cycle: inputs present before rising edge N appear on the outputs after edge N.
  - Reset value: `sum`=0, `carry`=0.
- Reset mid-operation (`OUT_REG=1`):
  - Asserting `rst_n` between edges clears the outputs immediately.
  - Inputs sampled while `rst_n`=0 are discarded.
  - Deassertion is assumed synchronous to `clk` by the surrounding design; a reset synchronizer is out of scope.
- Simultaneous input changes: the outputs reflect only the final input combination; no glitch-free guarantee is given for the combinational outputs.

## Test plan

- Exhaustive, WIDTH=1, OUT_REG=0: apply all 8 (a,b,cin) combinations in order 000..111, waiting 10 time units each. Required `sum`/`carry` sequence: 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- WIDTH=4, OUT_REG=0, full carry ripple: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, carry=1.
- WIDTH=4, OUT_REG=0:
  - a=4'h9, b=4'h6, cin=0 -> sum=4'hF, carry=0.
  - a=4'hF, b=4'hF, cin=1 -> sum=4'hF, carry=1.
- WIDTH=4, OUT_REG=1, reset and latency:
  - Hold `rst_n`=0 with a=4'h3, b=4'h4 -> sum=0, carry=0 across clock edges.
  - Release reset; after the next rising edge -> sum=4'h7, carry=0.
- WIDTH=4, OUT_REG=1, reset mid-operation: with outputs at sum=4'h7, pull `rst_n` low between edges -> sum=0, carry=0 before the next `clk` edge.
- Randomized, WIDTH=8, OUT_REG=0: 1000 random (a,b,cin) vectors -> `{carry,sum}` equals the 9-bit reference `a+b+cin` on every vector.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit unsigned adder, {carry, sum} = a + b + cin, built as a
// ripple chain of identical 1-bit full-adder cells. OUT_REG=1 places a
// flop stage (async active-low reset) on sum/carry; OUT_REG=0 is purely
// combinational and ignores clk/rst_n.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Ripple chain: each cell sums its bit pair with the incoming carry.
  always_comb begin
    chain    = '0;
    sum_comb = '0;
    chain[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_comb[i]  = a[i] ^ b[i] ^ chain[i];
      chain[i+1]   = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
  end

  // Output stage; reset clears immediately, loads every rising edge otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_comb;
      carry_q <= chain[WIDTH];
    end
  end

  // The flop stage always exists and OUT_REG selects it here; with OUT_REG=0
  // the constant select leaves the flops unloaded and they are trimmed away.
  always_comb begin
    if (OUT_REG) begin
      sum   = sum_q;
      carry = carry_q;
    end else begin
      sum   = sum_comb;
      carry = chain[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: exhaustive 1-bit, directed 4-bit,
// registered 4-bit reset/latency, and randomized 8-bit against a + b + cin.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // WIDTH=1, combinational
  logic       a1, b1, c1, s1, co1;
  logic       rst_n_comb = 1'b1;
  // WIDTH=4, combinational
  logic [3:0] a4, b4, s4;
  logic       c4, co4;
  // WIDTH=4, registered
  logic [3:0] ar, br, sr;
  logic       cr, cor, rst_n_reg;
  // WIDTH=8, combinational
  logic [7:0] a8, b8, s8;
  logic       c8, co8;

  full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n_comb), .a(a1), .b(b1), .cin(c1), .sum(s1), .carry(co1));
  full_adder #(.WIDTH(4), .OUT_REG(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n_comb), .a(a4), .b(b4), .cin(c4), .sum(s4), .carry(co4));
  full_adder #(.WIDTH(4), .OUT_REG(1'b1)) u_w4r (
    .clk(clk), .rst_n(rst_n_reg), .a(ar), .b(br), .cin(cr), .sum(sr), .carry(cor));
  full_adder #(.WIDTH(8), .OUT_REG(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n_comb), .a(a8), .b(b8), .cin(c8), .sum(s8), .carry(co8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: plain unsigned addition at WIDTH+1 bits.
  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input int unsigned w);
    logic [64:0] t;
    t = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    return t & ((65'd1 << (w + 1)) - 65'd1);
  endfunction

  // Watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  exp_tbl [8];
    logic [64:0] r;
    logic [3:0]  pa, pb;
    logic        pc;

    // {sum, carry} for a b cin = 000..111
    exp_tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    a1 = 0; b1 = 0; c1 = 0;
    a4 = '0; b4 = '0; c4 = 0;
    a8 = '0; b8 = '0; c8 = 0;
    ar = 4'h3; br = 4'h4; cr = 0;
    rst_n_reg = 1'b0;

    // Exhaustive 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #10;
      check($sformatf("w1_tt%0d", i), {62'd0, s1, co1}, {62'd0, exp_tbl[i]});
    end

    // Directed 4-bit combinational
    a4 = 4'hF; b4 = 4'h0; c4 = 1; #10;
    check("w4_ripple", {59'd0, co4, s4}, 64'h10);
    a4 = 4'h9; b4 = 4'h6; c4 = 0; #10;
    check("w4_9p6", {59'd0, co4, s4}, 64'h0F);
    a4 = 4'hF; b4 = 4'hF; c4 = 1; #10;
    check("w4_max", {59'd0, co4, s4}, 64'h1F);
    for (int i = 0; i < 16; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); #10;
      r = ref_add({60'd0, a4}, {60'd0, b4}, c4, 4);
      check("w4_rand", {59'd0, co4, s4}, r[63:0]);
    end

    // Registered: outputs held at zero while reset, across edges
    check("reg_rst_async", {59'd0, cor, sr}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reg_rst_hold", {59'd0, cor, sr}, 64'h0);
    end
    @(negedge clk); rst_n_reg = 1'b1;
    #1;
    check("reg_no_early_load", {59'd0, cor, sr}, 64'h0);
    @(posedge clk); #1;
    check("reg_first_load", {59'd0, cor, sr}, 64'h07);

    // One-cycle latency on a stream of random inputs
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pa = 4'($urandom); pb = 4'($urandom); pc = 1'($urandom);
      ar = pa; br = pb; cr = pc;
      #1;
      if (i > 0) check("reg_not_yet", {59'd0, cor, sr}, r[63:0]);
      r = ref_add({60'd0, pa}, {60'd0, pb}, pc, 4);
      @(posedge clk); #1;
      check("reg_latency", {59'd0, cor, sr}, r[63:0]);
    end

    // Mid-operation reset between edges
    @(negedge clk); ar = 4'h3; br = 4'h4; cr = 0;
    @(posedge clk); #1;
    check("reg_pre_midrst", {59'd0, cor, sr}, 64'h07);
    @(negedge clk); rst_n_reg = 1'b0;
    #1;
    check("reg_midrst_clear", {59'd0, cor, sr}, 64'h0);
    ar = 4'hF; br = 4'hF; cr = 1;
    @(posedge clk); #1;
    check("reg_rst_discard", {59'd0, cor, sr}, 64'h0);
    @(negedge clk); rst_n_reg = 1'b1;
    @(posedge clk); #1;
    check("reg_after_rst", {59'd0, cor, sr}, 64'h1F);

    // Randomized 8-bit combinational
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      #10;
      r = ref_add({56'd0, a8}, {56'd0, b8}, c8, 8);
      check("w8_rand", {55'd0, co8, s8}, r[63:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
